dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters.
  - m0: the core load/store path; this is the priority requester.
  - m1: a secondary master, e.g. a bench loader or DMA.
- Fixed priority to m0, with a starvation guard that forces a grant to m1 after a bounded wait.
- The memory is synchronous: a read issued in cycle N returns data in cycle N+1. The arbiter routes that data back to the requester that issued the read.
- m0_gnt low acts as the core stall: the core holds its PC and instruction while it is low.

---
 rtl/dmem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one synchronous data-memory port between m0 (core
// load/store, priority) and m1 (secondary master). A starvation counter forces
// a grant to m1 once it has been denied MAX_WAIT consecutive cycles. Read data
// returns one cycle after the grant and is steered back to the issuing master.
// Optional: define DMEM_ARB_STATS_EN to add saturating grant/conflict counters.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_m0_grants,
    output logic [15:0]       stat_m1_grants,
    output logic [15:0]       stat_conflicts
`endif
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_owner_q, rd_owner_d;   // 0 = m0, 1 = m1
    logic       force_m1;

    assign force_m1 = (starve_cnt_q == MAX_WAIT_C);

    // Grant decision; grants are held off while reset is asserted so no strobe
    // reaches memory during reset even if requests are already high.
    always_comb begin
        m0_gnt = rst_n && m0_req && !(force_m1 && m1_req);
        m1_gnt = rst_n && m1_req && (!m0_req || force_m1);
    end

    // Starvation counter: clears when m1 is served or idle, else counts up to MAX_WAIT.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (m1_gnt || !m1_req)
            starve_cnt_d = 4'd0;
        else if (starve_cnt_q != MAX_WAIT_C)
            starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // Memory-side mux from the granted master; idle port drives zeros.
    always_comb begin
        mem_en    = m0_gnt | m1_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end else if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end
    end

    // Read-return tracking: remember that a read went out this cycle and who owns it.
    always_comb begin
        rd_pend_d  = mem_en && !mem_we;
        rd_owner_d = m1_gnt;
    end

    // State registers; reset drops any in-flight read return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // Steer returning read data to its owner; the other master sees zero.
    always_comb begin
        m0_rvalid = rd_pend_q && !rd_owner_q;
        m1_rvalid = rd_pend_q &&  rd_owner_q;
        m0_rdata  = m0_rvalid ? mem_rdata : '0;
        m1_rdata  = m1_rvalid ? mem_rdata : '0;
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_m0_q, stat_m0_d;
    logic [15:0] stat_m1_q, stat_m1_d;
    logic [15:0] stat_cf_q, stat_cf_d;

    // Saturating event counters.
    always_comb begin
        stat_m0_d = stat_m0_q;
        stat_m1_d = stat_m1_q;
        stat_cf_d = stat_cf_q;
        if (m0_gnt && stat_m0_q != 16'hFFFF)
            stat_m0_d = stat_m0_q + 16'd1;
        if (m1_gnt && stat_m1_q != 16'hFFFF)
            stat_m1_d = stat_m1_q + 16'd1;
        if (m0_req && m1_req && stat_cf_q != 16'hFFFF)
            stat_cf_d = stat_cf_q + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_m0_q <= 16'd0;
            stat_m1_q <= 16'd0;
            stat_cf_q <= 16'd0;
        end else begin
            stat_m0_q <= stat_m0_d;
            stat_m1_q <= stat_m1_d;
            stat_cf_q <= stat_cf_d;
        end
    end

    assign stat_m0_grants = stat_m0_q;
    assign stat_m1_grants = stat_m1_q;
    assign stat_conflicts = stat_cf_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small synchronous memory model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_m0_grants, stat_m1_grants, stat_conflicts;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .stat_m0_grants(stat_m0_grants), .stat_m1_grants(stat_m1_grants),
        .stat_conflicts(stat_conflicts)
`endif
    );

    // Synchronous memory: read data appears the cycle after the strobe.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:2]];
    end

    task automatic drv_m0(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic drv_m1(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drv_m0(1'b1, 1'b0, 32'h0, 32'h0);
        drv_m1(1'b1, 1'b0, 32'h4, 32'h0);
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (m0_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_m0_gnt got %0h want 0", m0_gnt); end
        n_cmp++; if (m1_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_m1_gnt got %0h want 0", m1_gnt); end
        n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en got %0h want 0", mem_en); end
        n_cmp++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid got %0h/%0h want 0/0", m0_rvalid, m1_rvalid); end
        n_cmp++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %0h/%0h want 0/0", m0_rdata, m1_rdata); end
        @(negedge clk);
        rst_n = 1'b1; #1;
        n_cmp++; if (m0_gnt !== 1'b1) begin n_bad++; $display("FAIL rel_m0_gnt got %0h want 1", m0_gnt); end
        n_cmp++; if (m1_gnt !== 1'b0) begin n_bad++; $display("FAIL rel_m1_gnt got %0h want 0", m1_gnt); end
        n_cmp++; if (mem_en !== 1'b1 || mem_addr !== 32'h0) begin n_bad++; $display("FAIL rel_mem got en=%0h addr=%0h want 1/0", mem_en, mem_addr); end
        @(negedge clk);
        drv_m0(1'b0, 1'b0, 32'h0, 32'h0);
        drv_m1(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
    endtask

    task automatic test_write_read();
        @(negedge clk);
        drv_m0(1'b1, 1'b1, 32'h10, 32'hDEADBEEF); #1;
        n_cmp++; if (m0_gnt !== 1'b1) begin n_bad++; $display("FAIL wr_m0_gnt got %0h want 1", m0_gnt); end
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL wr_mem got we=%0h a=%0h d=%0h want 1/10/deadbeef", mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        drv_m0(1'b1, 1'b0, 32'h10, 32'h0); #1;
        n_cmp++; if (m0_gnt !== 1'b1 || mem_we !== 1'b0) begin n_bad++; $display("FAIL rd_m0_gnt got gnt=%0h we=%0h want 1/0", m0_gnt, mem_we); end
        n_cmp++; if (m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL wr_no_rvalid got %0h want 0", m0_rvalid); end
        @(negedge clk);
        drv_m0(1'b0, 1'b0, 32'h0, 32'h0); #1;
        n_cmp++; if (m0_rvalid !== 1'b1) begin n_bad++; $display("FAIL rd_m0_rvalid got %0h want 1", m0_rvalid); end
        n_cmp++; if (m0_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_m0_rdata got %0h want deadbeef", m0_rdata); end
        n_cmp++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin n_bad++; $display("FAIL rd_m1_quiet got %0h/%0h want 0/0", m1_rvalid, m1_rdata); end
        n_cmp++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL idle_mem got en=%0h we=%0h want 0/0", mem_en, mem_we); end
        @(negedge clk); #1;
        n_cmp++; if (m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_single_rvalid got %0h want 0", m0_rvalid); end
    endtask

    // Both masters request every cycle; m1 should win on cycles 4 and 9.
    task automatic run_starvation(input string tag);
        logic e1;
        @(negedge clk);
        drv_m0(1'b1, 1'b0, 32'h0, 32'h0);
        drv_m1(1'b1, 1'b0, 32'h4, 32'h0);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            e1 = (c == 4) || (c == 9);
            n_cmp++; if (m1_gnt !== e1 || m0_gnt !== !e1) begin
                n_bad++; $display("FAIL %s_gnt c=%0d got m0=%0h m1=%0h want m0=%0h m1=%0h", tag, c, m0_gnt, m1_gnt, !e1, e1); end
            n_cmp++; if (m1_rvalid !== (c == 5)) begin
                n_bad++; $display("FAIL %s_m1_rvalid c=%0d got %0h want %0h", tag, c, m1_rvalid, (c == 5)); end
            n_cmp++; if (m0_rvalid !== (c >= 1 && c != 5)) begin
                n_bad++; $display("FAIL %s_m0_rvalid c=%0d got %0h want %0h", tag, c, m0_rvalid, (c >= 1 && c != 5)); end
        end
        @(negedge clk);
        drv_m0(1'b0, 1'b0, 32'h0, 32'h0);
        drv_m1(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_starvation();
        run_starvation("starve");
        @(negedge clk);
    endtask

    task automatic test_interleave();
        int sel [6] = '{0, 1, 0, 1, 1, 2};  // 0 = m0 read, 1 = m1 read, 2 = idle
        int prev = 2;
        @(negedge clk);
        drv_m0(1'b1, 1'b1, 32'h20, 32'h11112222);
        @(negedge clk);
        drv_m0(1'b0, 1'b0, 32'h0, 32'h0);
        drv_m1(1'b1, 1'b1, 32'h24, 32'h33334444); #1;
        n_cmp++; if (m1_gnt !== 1'b1) begin n_bad++; $display("FAIL m1_alone_gnt got %0h want 1", m1_gnt); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drv_m0(sel[c] == 0, 1'b0, 32'h20, 32'h0);
            drv_m1(sel[c] == 1, 1'b0, 32'h24, 32'h0); #1;
            n_cmp++; if (m0_gnt !== (sel[c] == 0) || m1_gnt !== (sel[c] == 1)) begin
                n_bad++; $display("FAIL il_gnt c=%0d got %0h/%0h want %0h/%0h", c, m0_gnt, m1_gnt, sel[c] == 0, sel[c] == 1); end
            n_cmp++; if (m0_rvalid !== (prev == 0) || m1_rvalid !== (prev == 1)) begin
                n_bad++; $display("FAIL il_rvalid c=%0d got %0h/%0h want %0h/%0h", c, m0_rvalid, m1_rvalid, prev == 0, prev == 1); end
            n_cmp++; if (m0_rdata !== ((prev == 0) ? 32'h11112222 : 32'h0)) begin
                n_bad++; $display("FAIL il_m0_rdata c=%0d got %0h want %0h", c, m0_rdata, (prev == 0) ? 32'h11112222 : 32'h0); end
            n_cmp++; if (m1_rdata !== ((prev == 1) ? 32'h33334444 : 32'h0)) begin
                n_bad++; $display("FAIL il_m1_rdata c=%0d got %0h want %0h", c, m1_rdata, (prev == 1) ? 32'h33334444 : 32'h0); end
            prev = sel[c];
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        drv_m1(1'b1, 1'b0, 32'h24, 32'h0); #1;
        n_cmp++; if (m1_gnt !== 1'b1) begin n_bad++; $display("FAIL mr_m1_gnt got %0h want 1", m1_gnt); end
        #2 rst_n = 1'b0;
        @(negedge clk);
        drv_m1(1'b0, 1'b0, 32'h0, 32'h0); #1;
        n_cmp++; if (m1_rvalid !== 1'b0) begin n_bad++; $display("FAIL mr_rvalid_in_rst got %0h want 0", m1_rvalid); end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_cmp++; if (m1_rvalid !== 1'b0) begin n_bad++; $display("FAIL mr_rvalid_after c=%0d got %0h want 0", c, m1_rvalid); end
        end
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        rst_n = 1'b0; #1;
        n_cmp++; if (stat_m0_grants !== 16'd0 || stat_m1_grants !== 16'd0 || stat_conflicts !== 16'd0) begin
            n_bad++; $display("FAIL st_reset got %0d/%0d/%0d want 0/0/0", stat_m0_grants, stat_m1_grants, stat_conflicts); end
        @(negedge clk);
        rst_n = 1'b1;
        run_starvation("st");
        #1;
        n_cmp++; if (stat_m0_grants !== 16'd8) begin n_bad++; $display("FAIL st_m0 got %0d want 8", stat_m0_grants); end
        n_cmp++; if (stat_m1_grants !== 16'd2) begin n_bad++; $display("FAIL st_m1 got %0d want 2", stat_m1_grants); end
        n_cmp++; if (stat_conflicts !== 16'd10) begin n_bad++; $display("FAIL st_cf got %0d want 10", stat_conflicts); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        drv_m0(1'b0, 1'b0, 32'h0, 32'h0);
        drv_m1(1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_write_read();
        test_starvation();
        test_interleave();
        test_reset_mid_read();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
